c_gate_bit_bus_pipe_v5_0: RTL and testbench
===========================================

Name: c_gate_bit_bus_pipe_v5_0

Overview:
Multi-channel, runtime-configurable bit-to-bus gate with a parametrised register pipeline and valid/ready flow control. Each of C_NUM_CHANNELS lanes combines a C_WIDTH-bit bus with its own single control bit using an operation chosen per beat. A fixed per-bit input inversion mask is applied before the gate. It replaces single-lane, fixed-gate, single-register gate blocks in streaming datapaths that need backpressure.

Parameters:
C_WIDTH, 16, bits per channel (1..64)
C_NUM_CHANNELS, 2, number of independent lanes (1..16)
C_LATENCY, 1, pipeline register stages (1..4); 0 is illegal
C_INPUT_INV_MASK, all "0", C_WIDTH-char binary string, MSB first; same mask for every lane; '1' inverts that bit of I before the gate
C_HAS_OP_ERR, 1, 1 = OP_ERR port driven; 0 = OP_ERR tied 0

Ports:
CLK  in  1  rising-edge clock
SCLR_N  in  1  synchronous active-low reset
I  in  C_NUM_CHANNELS*C_WIDTH  input buses; lane n = I[n*C_WIDTH +: C_WIDTH]
CTRL  in  C_NUM_CHANNELS  control bit per lane
OP  in  3  gate select for this beat: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
S_VALID  in  1  input beat valid
S_READY  out  1  block can accept a beat
O  out  C_NUM_CHANNELS*C_WIDTH  gated result, registered
M_VALID  out  1  O holds a valid beat
M_READY  in  1  downstream accepts the beat
OP_ERR  out  1  sticky flag: an illegal OP was accepted

Behaviour:
- Reset: synchronous, active-low. When SCLR_N=0 at a rising CLK edge, all stage valid bits, O, and OP_ERR are cleared to 0.
- S_READY is 0 while SCLR_N=0 and in the cycle it is sampled low. Any beat in flight is discarded without output.
- Mask: C_INPUT_INV_MASK is converted to bits at elaboration. A character other than '0'/'1' is an elaboration error.
- Gate, per lane n, per bit j: x = I[n][j] ^ mask[j] and c = CTRL[n].
  - AND gives x&c; NAND gives ~(x&c); OR gives x|c; NOR gives ~(x|c); XOR gives x^c; XNOR gives ~(x^c).
  - OP 6/7 gives all-zero for the beat. The beat still flows. OP_ERR is set on acceptance and stays 1 until reset.
- Accept: a beat is accepted when S_VALID & S_READY at a rising edge. The gate result is computed combinationally and captured into stage 0.
- Pipeline: stages 0..C_LATENCY-1, each holding a valid bit and data. The last stage drives O and M_VALID.
  - Advance rule: adv[last] = ~v[last] | M_READY; adv[k] = ~v[k] | adv[k+1].
  - Stage k loads from stage k-1 (or from input for k=0) when adv[k]. Its valid becomes the upstream valid/accept.
  - S_READY = adv[0], which is combinational from M_READY through the stage valids. This collapses bubbles.
- Latency and throughput:
  - With M_READY=1, a beat accepted at edge t appears on O with M_VALID=1 after edge t+C_LATENCY-1, i.e. C_LATENCY edges after capture counting the capture edge.
  - Throughput is 1 beat/cycle. There is no loss or duplication under any M_READY pattern.
- Stall: if M_VALID=1 and M_READY=0, O and M_VALID hold stable. The pipeline fills up to C_LATENCY beats; S_READY then drops to 0.
- Simultaneous events: a full pipeline with M_READY=1 and S_VALID=1 accepts a new beat and emits one in the same cycle. Reset overrides every other event.
- OP, CTRL, and I are sampled only on the accept edge. Changes while S_READY=0 have no effect.
- Ordering is strictly FIFO.

Decomposition:
- Shared package c_gate_pkg holds:
  - op encodings (C_OP_AND..C_OP_XNOR, width 3);
  - the function mask_to_bits(string, width);
  - the function gate_bit(op, x, c).
- One sub-module, c_gate_pipe_stage: a single valid/data register stage with the adv input, instanced C_LATENCY times via generate.
- The gate logic stays in the top module, as a generate over lanes.

Test Plan:
- Reset plus idle. Hold SCLR_N=0 for 3 cycles with S_VALID=1 → O=0, M_VALID=0, S_READY=0, OP_ERR=0. After release, S_READY=1.
- Per-op check. C_WIDTH=4, C_NUM_CHANNELS=2, mask "0001", C_LATENCY=2. Lane0 I=4'b1010, CTRL=1; lane1 I=4'b0110, CTRL=0; sweep OP 0..5, M_READY=1.
  - x0=1011, x1=0111.
  - Required: AND → 1011/0000; NAND → 0100/1111; OR → 1111/0111; NOR → 0000/1000; XOR → 0100/0111; XNOR → 1011/1000.
  - Each result appears 2 cycles after accept.
- Backpressure. C_LATENCY=3, stream beats 1..8 with M_READY low for cycles 2..6.
  - S_READY drops after 3 beats are held. O/M_VALID stay stable while stalled.
  - Output order is 1..8, no gaps or duplicates. Back-to-back throughput resumes after M_READY returns.
- Illegal op. Send OP=6 with nonzero I → O=0 for that beat, OP_ERR rises the cycle after accept. It stays 1 through later legal beats until SCLR_N=0.
- Reset mid-stream. Pipeline full, assert SCLR_N=0 for one edge → all in-flight beats dropped, M_VALID=0 next cycle. The first post-reset beat emerges correctly with latency C_LATENCY.

Source files
------------

// File: rtl/c_gate_pkg.sv
// Shared definitions for the multi-lane bit-to-bus gate: op encodings,
// inversion-mask decoding and the single-bit gate function.
package c_gate_pkg;

  localparam logic [2:0] C_OP_AND  = 3'd0;
  localparam logic [2:0] C_OP_NAND = 3'd1;
  localparam logic [2:0] C_OP_OR   = 3'd2;
  localparam logic [2:0] C_OP_NOR  = 3'd3;
  localparam logic [2:0] C_OP_XOR  = 3'd4;
  localparam logic [2:0] C_OP_XNOR = 3'd5;

  localparam int C_MAX_WIDTH = 64;

  // Mask strings arrive as packed characters, last character (LSB) in bits [7:0].
  function automatic logic [C_MAX_WIDTH-1:0] mask_to_bits(input logic [8*C_MAX_WIDTH-1:0] s,
                                                          input int width);
    logic [C_MAX_WIDTH-1:0] bits;
    bits = {C_MAX_WIDTH{1'b0}};
    for (int j = 0; j < C_MAX_WIDTH; j++) begin
      if (j < width && s[8*j +: 8] == 8'h31) bits[j] = 1'b1;
      else                                   bits[j] = 1'b0;
    end
    return bits;
  endfunction

  function automatic logic mask_ok(input logic [8*C_MAX_WIDTH-1:0] s, input int width);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < C_MAX_WIDTH; j++) begin
      if (j < width && s[8*j +: 8] != 8'h30 && s[8*j +: 8] != 8'h31) ok = 1'b0;
      else                                                             ok = ok;
    end
    return ok;
  endfunction

  function automatic logic gate_bit(input logic [2:0] op, input logic x, input logic c);
    logic r;
    case (op)
      C_OP_AND:  r = x & c;
      C_OP_NAND: r = ~(x & c);
      C_OP_OR:   r = x | c;
      C_OP_NOR:  r = ~(x | c);
      C_OP_XOR:  r = x ^ c;
      C_OP_XNOR: r = ~(x ^ c);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/c_gate_bit_bus_pipe_v5_0_stage.sv
// One valid/data register stage of the gate pipeline; loads from upstream
// whenever its advance input is high.
module c_gate_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         sclr_n_i,
  input  logic         adv_i,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: data only moves with a real beat so O stays put across bubbles
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_i) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
      else            data_d = data_q;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage register with synchronous active-low clear
  always_ff @(posedge clk_i) begin
    if (!sclr_n_i) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/c_gate_bit_bus_pipe_v5_0.sv
// Multi-lane runtime-selectable bit-to-bus gate with a bubble-collapsing
// valid/ready register pipeline and a sticky illegal-op flag.
module c_gate_bit_bus_pipe_v5_0
  import c_gate_pkg::*;
#(
  parameter int                     C_WIDTH          = 16,
  parameter int                     C_NUM_CHANNELS   = 2,
  parameter int                     C_LATENCY        = 1,
  parameter logic [8*C_MAX_WIDTH-1:0] C_INPUT_INV_MASK = "0000000000000000",
  parameter int                     C_HAS_OP_ERR     = 1
) (
  input  logic                               CLK,
  input  logic                               SCLR_N,
  input  logic [C_NUM_CHANNELS*C_WIDTH-1:0]  I,
  input  logic [C_NUM_CHANNELS-1:0]          CTRL,
  input  logic [2:0]                         OP,
  input  logic                               S_VALID,
  output logic                               S_READY,
  output logic [C_NUM_CHANNELS*C_WIDTH-1:0]  O,
  output logic                               M_VALID,
  input  logic                               M_READY,
  output logic                               OP_ERR
);

  localparam int DW = C_NUM_CHANNELS * C_WIDTH;
  localparam logic [C_MAX_WIDTH-1:0] MASK_ALL = mask_to_bits(C_INPUT_INV_MASK, C_WIDTH);
  localparam logic [C_WIDTH-1:0]     MASK     = MASK_ALL[C_WIDTH-1:0];

  if (!mask_ok(C_INPUT_INV_MASK, C_WIDTH)) begin : g_bad_mask
    $error("C_INPUT_INV_MASK may contain only '0' and '1' characters");
  end
  if (C_LATENCY < 1 || C_LATENCY > 4) begin : g_bad_latency
    $error("C_LATENCY must be in 1..4");
  end

  logic [DW-1:0]                gated_s;
  logic [C_LATENCY:0]           adv_s;
  logic [C_LATENCY-1:0]         vld_s;
  logic [C_LATENCY-1:0][DW-1:0] dat_s;
  logic                         acc_s;

  for (genvar n = 0; n < C_NUM_CHANNELS; n++) begin : g_lane
    for (genvar j = 0; j < C_WIDTH; j++) begin : g_bit
      assign gated_s[n*C_WIDTH + j] = gate_bit(OP, I[n*C_WIDTH + j] ^ MASK[j], CTRL[n]);
    end
  end

  // A stage may advance if it is empty or everything downstream advances
  assign adv_s[C_LATENCY] = M_READY;

  for (genvar k = 0; k < C_LATENCY; k++) begin : g_stage
    logic          up_v_s;
    logic [DW-1:0] up_d_s;
    if (k == 0) begin : g_head
      assign up_v_s = S_VALID;
      assign up_d_s = gated_s;
    end else begin : g_body
      assign up_v_s = vld_s[k-1];
      assign up_d_s = dat_s[k-1];
    end
    assign adv_s[k] = ~vld_s[k] | adv_s[k+1];
    c_gate_pipe_stage #(.W(DW)) u_stage (
      .clk_i      (CLK),
      .sclr_n_i   (SCLR_N),
      .adv_i      (adv_s[k]),
      .up_valid_i (up_v_s),
      .up_data_i  (up_d_s),
      .valid_o    (vld_s[k]),
      .data_o     (dat_s[k])
    );
  end

  assign S_READY = adv_s[0] & SCLR_N;
  assign acc_s   = S_VALID & S_READY;
  assign O       = dat_s[C_LATENCY-1];
  assign M_VALID = vld_s[C_LATENCY-1];

  if (C_HAS_OP_ERR != 0) begin : g_op_err
    logic op_err_q, op_err_d;

    // Sticky: set on accepting an illegal op, cleared only by reset
    always_comb begin
      op_err_d = op_err_q;
      if (acc_s && (OP > C_OP_XNOR)) op_err_d = 1'b1;
      else                           op_err_d = op_err_q;
    end

    // Flag register with synchronous active-low clear
    always_ff @(posedge CLK) begin
      if (!SCLR_N) op_err_q <= 1'b0;
      else         op_err_q <= op_err_d;
    end

    assign OP_ERR = op_err_q;
  end else begin : g_no_op_err
    assign OP_ERR = 1'b0;
  end

endmodule

// File: tb/tb_c_gate_bit_bus_pipe_v5_0.sv
// Bench for c_gate_bit_bus_pipe_v5_0: directed and random beats checked
// against a timing/ordering model of the gate pipeline.
module tb_c_gate_bit_bus_pipe_v5_0;

  localparam int L = 3;
  localparam logic [3:0] MASK = 4'b0001;

  logic       CLK = 1'b0;
  logic       SCLR_N, S_VALID, M_READY;
  logic [7:0] I;
  logic [1:0] CTRL;
  logic [2:0] OP;
  logic       S_READY, M_VALID, OP_ERR;
  logic [7:0] O;

  c_gate_bit_bus_pipe_v5_0 #(
    .C_WIDTH(4), .C_NUM_CHANNELS(2), .C_LATENCY(L),
    .C_INPUT_INV_MASK("0001"), .C_HAS_OP_ERR(1)
  ) dut (
    .CLK(CLK), .SCLR_N(SCLR_N), .I(I), .CTRL(CTRL), .OP(OP),
    .S_VALID(S_VALID), .S_READY(S_READY), .O(O), .M_VALID(M_VALID),
    .M_READY(M_READY), .OP_ERR(OP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] data; int ready; } beat_t;
  beat_t      q[$];
  logic [7:0] out_log[$];
  int         checks = 0, errors = 0, n_edges = 0;
  logic       m_err = 1'b0, clean = 1'b1;

  function automatic logic [7:0] ref_gate(input logic [7:0] din, input logic [1:0] ct,
                                          input logic [2:0] op);
    logic [7:0] r;
    logic [3:0] x, c;
    for (int n = 0; n < 2; n++) begin
      x = din[n*4 +: 4] ^ MASK;
      c = ct[n] ? 4'hF : 4'h0;
      case (op)
        3'd0: r[n*4 +: 4] = x & c;
        3'd1: r[n*4 +: 4] = ~(x & c);
        3'd2: r[n*4 +: 4] = x | c;
        3'd3: r[n*4 +: 4] = ~(x | c);
        3'd4: r[n*4 +: 4] = x ^ c;
        3'd5: r[n*4 +: 4] = ~(x ^ c);
        default: r[n*4 +: 4] = 4'h0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  // One clock cycle: drive, check against model, clock, update model.
  task automatic step(input logic rn, input logic sv, input logic mr, input logic [7:0] din,
                      input logic [1:0] ct, input logic [2:0] op,
                      output logic acc, output logic sr_obs);
    logic exp_sr, exp_mv;
    SCLR_N = rn; S_VALID = sv; M_READY = mr; I = din; CTRL = ct; OP = op;
    #1;
    exp_sr = rn && ((q.size() < L) || mr);
    exp_mv = (q.size() > 0) && (q[0].ready <= n_edges);
    sr_obs = S_READY;
    check("s_ready", S_READY, exp_sr);
    check("m_valid", M_VALID, exp_mv);
    if (exp_mv) begin
      check("o_data", O, q[0].data);
      clean = 1'b0;
      if (mr) out_log.push_back(O);
    end else if (clean) begin
      check("o_idle", O, 8'h00);
    end
    check("op_err", OP_ERR, m_err);
    acc = sv && exp_sr;
    @(posedge CLK);
    n_edges++;
    if (!rn) begin
      q.delete();
      m_err = 1'b0;
      clean = 1'b1;
    end else begin
      if (exp_mv && mr) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].ready < n_edges) q[0].ready = n_edges;
      end
      if (acc) begin
        q.push_back('{ref_gate(din, ct, op), n_edges + L - 1});
        if (op > 3'd5) m_err = 1'b1;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    logic a, sr;
    int   beat, stall_seen;
    logic [7:0] op_tbl [6];
    op_tbl = '{8'h0B, 8'hF4, 8'h7F, 8'h80, 8'h74, 8'h8B};

    // Settle the registers before the first comparisons
    SCLR_N = 1'b0; S_VALID = 1'b1; M_READY = 1'b1; I = 8'h00; CTRL = 2'b00; OP = 3'd0;
    @(posedge CLK); n_edges++; @(negedge CLK);

    // Reset held with S_VALID=1
    repeat (3) step(1'b0, 1'b1, 1'b1, 8'hA5, 2'b11, 3'd0, a, sr);
    step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 3'd0, a, sr);
    check("ready_after_reset", sr, 1'b1);

    // Per-op sweep, back-to-back
    out_log.delete();
    for (int op = 0; op < 6; op++) step(1'b1, 1'b1, 1'b1, 8'h6A, 2'b01, 3'(op), a, sr);
    repeat (L + 2) step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 3'd0, a, sr);
    check("op_sweep_count", 8'(out_log.size()), 8'd6);
    for (int k = 0; k < 6 && k < out_log.size(); k++) check("op_sweep_val", out_log[k], op_tbl[k]);

    // Backpressure: beats 1..8, M_READY low in cycles 2..6
    out_log.delete();
    beat = 1; stall_seen = 0;
    for (int cyc = 1; cyc <= 40 && out_log.size() < 8; cyc++) begin
      step(1'b1, beat <= 8, !(cyc >= 2 && cyc <= 6), 8'(beat), 2'b00, 3'd4, a, sr);
      if (beat <= 8 && !sr) stall_seen++;
      if (a) beat++;
    end
    check("bp_count", 8'(out_log.size()), 8'd8);
    check("bp_stall_seen", 8'(stall_seen > 0), 8'd1);
    for (int k = 0; k < out_log.size(); k++) check("bp_order", out_log[k], 8'(k + 1) ^ 8'h11);

    // Illegal op then legal beats: OP_ERR sticks
    out_log.delete();
    step(1'b1, 1'b1, 1'b1, 8'hFF, 2'b11, 3'd6, a, sr);
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 1'b1, 8'($urandom), 2'($urandom), 3'($urandom_range(0, 5)), a, sr);
    repeat (L + 1) step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 3'd0, a, sr);
    if (out_log.size() > 0) check("illegal_zero", out_log[0], 8'h00);
    else check("illegal_seen", 8'd0, 8'd1);
    check("op_err_sticky", OP_ERR, 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), 8'($urandom),
           2'($urandom), 3'(($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 5)), a, sr);

    // Reset mid-stream with a full pipeline
    for (int k = 0; k < L + 2; k++)
      step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'($urandom), 3'($urandom_range(0, 5)), a, sr);
    step(1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 3'd0, a, sr);
    check("mv_after_reset", M_VALID, 1'b0);
    out_log.delete();
    step(1'b1, 1'b1, 1'b1, 8'h3C, 2'b10, 3'd2, a, sr);
    repeat (L + 1) step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 3'd0, a, sr);
    check("post_reset_count", 8'(out_log.size()), 8'd1);
    if (out_log.size() > 0) check("post_reset_val", out_log[0], 8'hFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
